// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer and HI/LO block.
// Holds the op encodings, the FSM state type and the default widths.
package muldiv_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = $clog2(DEF_WIDTH);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;
endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the magnitude datapath.
//   i_div=0 : shift-add multiply. {i_acc,i_lo} is the running product with the
//             multiplier in the low half; i_opnd is the multiplicand.
//   i_div=1 : restoring divide. i_acc is the partial remainder, i_lo holds the
//             dividend bits being shifted out and quotient bits shifted in;
//             i_opnd is the divisor.
// Ports: i_div, i_acc, i_lo, i_opnd -> o_acc, o_lo (next-iteration values).
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_opnd,
  output logic [WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0] o_lo
);
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shl;
  logic [WIDTH-1:0] w_diff;

  always_comb begin
    w_sum  = {1'b0, i_acc} + (i_lo[0] ? {1'b0, i_opnd} : '0);
    w_shl  = {i_acc, i_lo[WIDTH-1]};
    // When the trial subtract succeeds the true difference is below the
    // divisor, so the low WIDTH bits are exact.
    w_diff = w_shl[WIDTH-1:0] - i_opnd;
    o_acc  = '0;
    o_lo   = '0;
    if (i_div) begin
      if (w_shl >= {1'b0, i_opnd}) begin
        o_acc = w_diff;
        o_lo  = {i_lo[WIDTH-2:0], 1'b1};
      end else begin
        o_acc = w_shl[WIDTH-1:0];
        o_lo  = {i_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      o_acc = w_sum[WIDTH:1];
      o_lo  = {w_sum[0], i_lo[WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer plus the HI/LO registers.
// Operands are reduced to magnitudes at acceptance, iterated one bit per cycle
// in muldiv_step, then sign-corrected in FIX before HI/LO are written.
// Ports: clk, rst_n (async, active low), start, op[2:0], a, b, abort
//        -> busy, done (1-cycle pulse on HI/LO update), hi, lo, div_zero.
// Optional feature: MULDIV_EARLY_OUT_EN -- trivially-zero multiplies and
// divides with |a|<|b| go straight from IDLE to FIX.
module muldiv_hilo_ctrl
  import muldiv_pkg::*;
#(
  parameter int               WIDTH    = DEF_WIDTH,
  parameter logic [WIDTH-1:0] HILO_RST = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH);

  state_e           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_pacc, r_plo, r_opnd;
  logic             r_div, r_neg_q, r_neg_r, r_dz;
  logic             r_busy, r_done, r_div_zero;
  logic [WIDTH-1:0] r_hi, r_lo;

  logic             w_signed, w_is_md, w_is_div, w_neg_a, w_neg_b, w_accept, w_early;
  logic [WIDTH-1:0] w_abs_a, w_abs_b, w_acc_nxt, w_lo_nxt;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;

  assign w_signed = ~op[0];
  assign w_is_md  = ~op[2];
  assign w_is_div = op[1];
  assign w_neg_a  = w_signed & a[WIDTH-1];
  assign w_neg_b  = w_signed & b[WIDTH-1];
  assign w_abs_a  = w_neg_a ? -a : a;
  assign w_abs_b  = w_neg_b ? -b : b;
  // busy is low exactly when IDLE, so this also covers "start ignored while busy".
  assign w_accept = (r_state == IDLE) & start & ~abort;

`ifdef MULDIV_EARLY_OUT_EN
  assign w_early = w_is_div ? (w_abs_a < w_abs_b) : ((a == '0) | (b == '0));
`else
  assign w_early = 1'b0;
`endif

  assign w_prod     = {r_pacc, r_plo};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_div  (r_div),
    .i_acc  (r_pacc),
    .i_lo   (r_plo),
    .i_opnd (r_opnd),
    .o_acc  (w_acc_nxt),
    .o_lo   (w_lo_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_pacc     <= '0;
      r_plo      <= '0;
      r_opnd     <= '0;
      r_div      <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dz       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= HILO_RST;
      r_lo       <= HILO_RST;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (w_accept) begin
          if (w_is_md) begin
            r_div      <= w_is_div;
            r_neg_q    <= w_neg_a ^ w_neg_b;
            r_neg_r    <= w_neg_a;          // remainder follows the dividend
            r_dz       <= w_is_div & (b == '0);
            r_div_zero <= 1'b0;
            r_busy     <= 1'b1;
            r_cnt      <= '0;
            r_opnd     <= w_is_div ? w_abs_b : w_abs_a;
            if (w_early) begin
              // Result is already known: product 0, or quotient 0 / remainder |a|.
              r_pacc  <= w_is_div ? w_abs_a : '0;
              r_plo   <= '0;
              r_state <= FIX;
            end else begin
              r_pacc  <= '0;
              r_plo   <= w_is_div ? w_abs_a : w_abs_b;
              r_state <= RUN;
            end
          end else if (op == OP_MTHI) begin
            r_hi   <= a;
            r_done <= 1'b1;
          end else if (op == OP_MTLO) begin
            r_lo   <= a;
            r_done <= 1'b1;
          end
        end
        RUN: if (abort) begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end else begin
          r_pacc <= w_acc_nxt;
          r_plo  <= w_lo_nxt;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) r_state <= FIX;
        end
        FIX: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          if (!abort) begin
            r_done     <= 1'b1;
            r_div_zero <= r_dz;
            if (r_div) begin
              r_hi <= r_neg_r ? -r_pacc : r_pacc;
              // Divide by zero reports all-ones regardless of signs.
              r_lo <= r_dz ? '1 : (r_neg_q ? -r_plo : r_plo);
            end else begin
              {r_hi, r_lo} <= w_prod_fix;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign div_zero = r_div_zero;
endmodule
